gpio_out_ctrl: RTL
==================

GPIO_OUT_CTRL -- requirements
Module: gpio_out_ctrl

Interface
REQ-001 Parameter LVL_W, default 5: LCD backlight level field width (2..8).
REQ-002 Parameter ACT_N, default 2: activity LED channel count (1..8).
REQ-003 Parameter DRV_N, default 2: drive-enable channel count (1..8); ch0 = shutter, ch1 = focus.
REQ-004 Parameter PWR_HOLD, default 1000: consecutive cycles gpio[0] must be high before pwr_off_req asserts (>=1).
REQ-005 Parameter PWM_DIV, default 64: clk cycles per PWM tick (>=1).
REQ-006 Parameter BLINK_DIV, default 25000000: clk cycles per blink phase toggle (>=1).
REQ-007 Parameter DRV_MAX, default 50000000: maximum continuous drive-enable on-time in cycles (>=2).
REQ-008 Localparam GPIO_W = 1 + LVL_W + 2*ACT_N + DRV_N (default 12).
REQ-009 clk  input  1  single clock; all logic synchronous to rising edge.
REQ-010 rst  input  1  synchronous, active-high reset.
REQ-011 gpio  input  GPIO_W  control word from AXI GPIO, same clock domain, no synchroniser.
REQ-012 pwr_off_req  output  1  qualified power-off request.
REQ-013 lcd_led_pwm  output  1  PWM backlight drive.
REQ-014 act_led  output  ACT_N  activity LED drives.
REQ-015 drv_ena  output  DRV_N  shutter/focus drive enables.
REQ-016 drv_timeout  output  DRV_N  one-cycle pulse per channel on on-time violation.

Function
REQ-017 Field map: gpio[0] power-off; gpio[LVL_W:1] level L; then ACT_N 2-bit LED mode fields, ch0 lowest; then DRV_N drive request bits, ch0 lowest.
REQ-018 All outputs registered; every output except pwr_off_req reflects a gpio change no later than 1 cycle after it (subject to PWM/blink phase).
REQ-019 Power-off: hold counter increments while gpio[0]=1, saturates at PWR_HOLD; pwr_off_req=1 when counter==PWR_HOLD; gpio[0]=0 clears counter and deasserts pwr_off_req next cycle.
REQ-020 Power-off latency: gpio[0] rising at cycle 0 -> pwr_off_req high at cycle PWR_HOLD; any low cycle restarts the count.
REQ-021 PWM: prescaler emits a tick every PWM_DIV cycles; on each tick, phase counter P steps 0..2^LVL_W-2 and wraps to 0 (period 2^LVL_W-1 ticks).
REQ-022 PWM level latched into L_q on the tick where P wraps to 0; L changes mid-period have no effect until next period.
REQ-023 lcd_led_pwm = (P < L_q); L_q=0 -> constant 0; L_q=2^LVL_W-1 -> constant 1; duty = L_q/(2^LVL_W-1).
REQ-024 Blink: shared counter toggles shared phase bit B every BLINK_DIV cycles, free-running, common to all LED channels.
REQ-025 LED mode per channel: 00 off, 01 on, 10 = B, 11 = ~B.
REQ-026 Drive FSM per channel, states IDLE, ON, LOCKOUT; drv_ena[i]=1 only in ON.
REQ-027 IDLE: request=1 -> ON, on-timer cleared to 0.
REQ-028 ON: on-timer increments each cycle; request=0 -> IDLE (takes priority); timer==DRV_MAX-1 with request=1 -> LOCKOUT and drv_timeout[i]=1 for that one cycle.
REQ-029 Max on-time: drv_ena[i] high for exactly DRV_MAX cycles under continuous request.
REQ-030 LOCKOUT: drv_ena[i]=0; stays until request=0, then IDLE; re-arming requires a 0 then 1 on the request bit.
REQ-031 Drive channels are fully independent; simultaneous events on different channels are handled each cycle without interaction.
REQ-032 Counter widths are sized by $clog2 of their parameter; no counter wraps except the PWM phase and blink counters.

Reset
REQ-033 rst=1 forces all outputs to 0, all counters/prescalers to 0, L_q=0, B=0, all drive FSMs to IDLE on the next edge.
REQ-034 rst asserted mid-operation (ON, LOCKOUT, partial hold count) aborts immediately; no drv_timeout pulse is generated by reset.
REQ-035 After rst release, the first PWM tick occurs PWM_DIV cycles later and the first blink toggle BLINK_DIV cycles later.

Verification (bench params: LVL_W=3, PWR_HOLD=4, PWM_DIV=1, BLINK_DIV=3, DRV_MAX=8)
REQ-036 gpio[0]=1 for 3 cycles, 0 for 1 cycle, then 1 held -> pwr_off_req stays 0 through the first burst, then rises 4 cycles after the re-assert.
REQ-037 L=3, steady -> after latch, lcd_led_pwm high 3 of every 7 cycles; L=7 -> constant 1; L=0 -> constant 0; L changed mid-period -> applied only at next wrap.
REQ-038 act modes ch0=10, ch1=11 -> ch0 toggles every 3 cycles starting low after reset, ch1 is its exact complement; mode 01 -> constant 1.
REQ-039 drv request ch0 held high 20 cycles -> drv_ena[0] high exactly 8 cycles, drv_timeout[0] single pulse, stays low until request drops and rises again.
REQ-040 ch1 request dropped at on-cycle 5 -> drv_ena[1] low next cycle, no timeout; rst asserted during ch0 ON -> drv_ena[0]=0 next cycle, FSM IDLE, no pulse.

Source files
------------

// File: rtl/gpio_out_ctrl.sv
// gpio_out_ctrl
//   Turns the AXI GPIO control word into registered board-level drives. It
//   handles four jobs:
//     - a qualified power-off request, which asserts only after gpio[0] has
//       been held high for PWR_HOLD cycles;
//     - a PWM backlight whose level is latched once per PWM period;
//     - activity LEDs that are off, on, or blinking in either phase of a
//       shared blink clock;
//     - shutter/focus drive enables, each with a maximum on-time lockout.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   gpio         control word, from lowest bit to highest:
//                  [0]                 power-off request
//                  [LVL_W:1]           backlight level
//                  then ACT_N 2-bit    LED mode fields
//                  then DRV_N          drive request bits
//   pwr_off_req  qualified power-off request
//   lcd_led_pwm  backlight PWM drive
//   act_led      activity LED drives (ACT_N)
//   drv_ena      drive enables (DRV_N); ch0 = shutter, ch1 = focus
//   drv_timeout  one-cycle pulse when a channel hits its on-time limit
module gpio_out_ctrl #(
  parameter  int LVL_W     = 5,
  parameter  int ACT_N     = 2,
  parameter  int DRV_N     = 2,
  parameter  int PWR_HOLD  = 1000,
  parameter  int PWM_DIV   = 64,
  parameter  int BLINK_DIV = 25000000,
  parameter  int DRV_MAX   = 50000000,
  localparam int GPIO_W    = 1 + LVL_W + 2*ACT_N + DRV_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] gpio,
  output logic              pwr_off_req,
  output logic              lcd_led_pwm,
  output logic [ACT_N-1:0]  act_led,
  output logic [DRV_N-1:0]  drv_ena,
  output logic [DRV_N-1:0]  drv_timeout
);

  localparam int ACT_LSB = 1 + LVL_W;
  localparam int DRV_LSB = ACT_LSB + 2*ACT_N;
  localparam int HOLD_W  = $clog2(PWR_HOLD + 1);
  localparam int PRE_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int BLK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TMR_W   = $clog2(DRV_MAX);
  localparam logic [LVL_W-1:0] PHASE_LAST = LVL_W'((1 << LVL_W) - 2);

  logic [LVL_W-1:0] level;
  logic [DRV_N-1:0] drv_req;

  assign level   = gpio[LVL_W:1];
  assign drv_req = gpio[DRV_LSB +: DRV_N];

  // ---------------------------------------------------------------------------
  // Power-off qualification. The count saturates at PWR_HOLD and is cleared
  // by any low cycle. The request is registered from the next count, so it
  // rises exactly PWR_HOLD cycles after gpio[0] rises.
  // ---------------------------------------------------------------------------
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (!gpio[0])
      hold_cnt_next = '0;
    else if (hold_cnt_reg != HOLD_W'(PWR_HOLD))
      hold_cnt_next = hold_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_reg <= '0;
      pwr_off_req  <= 1'b0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      pwr_off_req  <= (hold_cnt_next == HOLD_W'(PWR_HOLD));
    end
  end

  // ---------------------------------------------------------------------------
  // Backlight PWM. The phase runs 0..2^LVL_W-2, giving a period of
  // 2^LVL_W-1 ticks, so the full-scale level 2^LVL_W-1 yields a constant
  // high output. The level is sampled only on the wrap tick, which keeps
  // every period glitch-free.
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0] pre_cnt_reg, pre_cnt_next;
  logic [LVL_W-1:0] phase_reg, phase_next;
  logic [LVL_W-1:0] lvl_q_reg, lvl_q_next;
  logic             pwm_tick, pwm_wrap;

  assign pwm_tick = (pre_cnt_reg == PRE_W'(PWM_DIV - 1));
  assign pwm_wrap = pwm_tick && (phase_reg == PHASE_LAST);

  always_comb begin
    pre_cnt_next = pwm_tick ? '0 : pre_cnt_reg + 1'b1;
    phase_next   = phase_reg;
    lvl_q_next   = lvl_q_reg;
    if (pwm_wrap) begin
      phase_next = '0;
      lvl_q_next = level;
    end else if (pwm_tick) begin
      phase_next = phase_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_reg <= '0;
      phase_reg   <= '0;
      lvl_q_reg   <= '0;
      lcd_led_pwm <= 1'b0;
    end else begin
      pre_cnt_reg <= pre_cnt_next;
      phase_reg   <= phase_next;
      lvl_q_reg   <= lvl_q_next;
      lcd_led_pwm <= (phase_next < lvl_q_next);
    end
  end

  // ---------------------------------------------------------------------------
  // Shared blink phase and activity LEDs. The blink counter is free-running.
  // The mode encoding decodes as follows: the high bit selects blink, and
  // the low bit is either the constant level or the blink inversion.
  // ---------------------------------------------------------------------------
  logic [BLK_W-1:0] blk_cnt_reg;
  logic             blink_reg, blink_next, blink_tick;
  logic [ACT_N-1:0] act_next;

  assign blink_tick = (blk_cnt_reg == BLK_W'(BLINK_DIV - 1));
  assign blink_next = blink_reg ^ blink_tick;

  for (genvar gi = 0; gi < ACT_N; gi++) begin : g_act
    logic [1:0] mode;
    assign mode         = gpio[ACT_LSB + 2*gi +: 2];
    assign act_next[gi] = mode[1] ? (blink_next ^ mode[0]) : mode[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_reg <= '0;
      blink_reg   <= 1'b0;
      act_led     <= '0;
    end else begin
      blk_cnt_reg <= blink_tick ? '0 : blk_cnt_reg + 1'b1;
      blink_reg   <= blink_next;
      act_led     <= act_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Drive channels. Each channel has its own FSM with no shared state. The
  // on-timer counts 0..DRV_MAX-1 while ON, so the enable stays high for
  // exactly DRV_MAX cycles. LOCKOUT forces a release of the request before
  // the channel can re-arm.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    DRV_IDLE    = 2'd0,
    DRV_ON      = 2'd1,
    DRV_LOCKOUT = 2'd2
  } drv_state_t;

  for (genvar gi = 0; gi < DRV_N; gi++) begin : g_drv
    drv_state_t       state_reg;
    logic [TMR_W-1:0] timer_reg;
    logic             ena_reg;
    logic             timeout_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg   <= DRV_IDLE;
        timer_reg   <= '0;
        ena_reg     <= 1'b0;
        timeout_reg <= 1'b0;
      end else begin
        timeout_reg <= 1'b0;
        case (state_reg)
          DRV_IDLE: begin
            if (drv_req[gi]) begin
              state_reg <= DRV_ON;
              timer_reg <= '0;
              ena_reg   <= 1'b1;
            end
          end
          DRV_ON: begin
            // Releasing the request wins over reaching the limit.
            if (!drv_req[gi]) begin
              state_reg <= DRV_IDLE;
              ena_reg   <= 1'b0;
            end else if (timer_reg == TMR_W'(DRV_MAX - 1)) begin
              state_reg   <= DRV_LOCKOUT;
              ena_reg     <= 1'b0;
              timeout_reg <= 1'b1;
            end else begin
              timer_reg <= timer_reg + 1'b1;
            end
          end
          DRV_LOCKOUT: begin
            if (!drv_req[gi])
              state_reg <= DRV_IDLE;
          end
          default: begin
            state_reg <= DRV_IDLE;
            ena_reg   <= 1'b0;
          end
        endcase
      end
    end

    assign drv_ena[gi]     = ena_reg;
    assign drv_timeout[gi] = timeout_reg;
  end

endmodule
